// File: rtl/jt7759_feeder.sv
// jt7759_feeder: host-side master for the JT7759 slave-mode bus.
// It starts playback of a sample number, then answers each drqn request with
// one byte read from a host memory port, written through cs/wrn/din.
//
// Memory handshake: mem_cs is a level request. mem_addr is held constant while
// mem_cs is high. The first clk edge that sees mem_ok with mem_cs high captures
// mem_data and drops mem_cs on that same edge. mem_ok without mem_cs is ignored.
//
// Chip-side outputs (stn, cs, wrn, din) only move on cen edges. The only
// exceptions are abort and reset, which take effect on the next clk or at once.

module jt7759_feeder #(
    parameter int AW       = 20,
    parameter int LW       = 16,
    parameter int WAIT_CEN = 20
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic          cmd_go,
    input  logic          cmd_stop,
    input  logic [7:0]    cmd_num,
    input  logic [AW-1:0] cmd_addr,
    input  logic [LW-1:0] cmd_len,
    output logic          busy,
    output logic          done,
    output logic [LW-1:0] sent,
    output logic          stn,
    output logic          cs,
    output logic          wrn,
    output logic [7:0]    din,
    input  logic          drqn,
    input  logic          busyn,
    output logic          mem_cs,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_data,
    input  logic          mem_ok
);

    // The delay counter saturates at WAIT_CEN, so it must be able to hold that value
    localparam int DW = $clog2(WAIT_CEN + 2);
    localparam logic [DW-1:0] DLY_MAX = DW'(WAIT_CEN);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAITRQ,
        ST_FETCH,
        ST_WRITE,
        ST_RELEASE
    } state_t;

    // Registered state
    state_t          r_state;
    logic            r_stn;
    logic            r_cs;
    logic            r_wrn;
    logic [7:0]      r_din;
    logic            r_mem_cs;
    logic [AW-1:0]   r_mem_addr;
    logic            r_busy;
    logic            r_done;
    logic [LW-1:0]   r_sent;
    logic [7:0]      r_num;
    logic [AW-1:0]   r_addr;
    logic [LW-1:0]   r_len;
    logic [7:0]      r_byte;
    logic            r_have;
    logic [DW-1:0]   r_dly;
    logic [1:0]      r_sub;

    // Next-state values
    state_t          w_state;
    logic            w_stn;
    logic            w_cs;
    logic            w_wrn;
    logic [7:0]      w_din;
    logic            w_mem_cs;
    logic [AW-1:0]   w_mem_addr;
    logic            w_busy;
    logic            w_done;
    logic [LW-1:0]   w_sent;
    logic [7:0]      w_num;
    logic [AW-1:0]   w_addr;
    logic [LW-1:0]   w_len;
    logic [7:0]      w_byte;
    logic            w_have;
    logic [DW-1:0]   w_dly;
    logic [1:0]      w_sub;

    // Helpers
    logic            w_finish;
    logic [DW-1:0]   w_dly_inc;
    logic            w_got;
    logic            w_ready;
    logic [7:0]      w_wbyte;

    // State and datapath registers, asynchronously reset to the idle bus state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_stn      <= 1'b1;
            r_cs       <= 1'b0;
            r_wrn      <= 1'b1;
            r_din      <= 8'h00;
            r_mem_cs   <= 1'b0;
            r_mem_addr <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_sent     <= '0;
            r_num      <= 8'h00;
            r_addr     <= '0;
            r_len      <= '0;
            r_byte     <= 8'h00;
            r_have     <= 1'b0;
            r_dly      <= '0;
            r_sub      <= 2'd0;
        end else begin
            r_state    <= w_state;
            r_stn      <= w_stn;
            r_cs       <= w_cs;
            r_wrn      <= w_wrn;
            r_din      <= w_din;
            r_mem_cs   <= w_mem_cs;
            r_mem_addr <= w_mem_addr;
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_sent     <= w_sent;
            r_num      <= w_num;
            r_addr     <= w_addr;
            r_len      <= w_len;
            r_byte     <= w_byte;
            r_have     <= w_have;
            r_dly      <= w_dly;
            r_sub      <= w_sub;
        end
    end

    // Next-state and output logic; abort has the last word over everything
    always_comb begin
        w_state    = r_state;
        w_stn      = r_stn;
        w_cs       = r_cs;
        w_wrn      = r_wrn;
        w_din      = r_din;
        w_mem_cs   = r_mem_cs;
        w_mem_addr = r_mem_addr;
        w_busy     = r_busy;
        w_done     = 1'b0;
        w_sent     = r_sent;
        w_num      = r_num;
        w_addr     = r_addr;
        w_len      = r_len;
        w_byte     = r_byte;
        w_have     = r_have;
        w_dly      = r_dly;
        w_sub      = r_sub;
        w_finish   = 1'b0;
        w_dly_inc  = (r_dly == DLY_MAX) ? r_dly : r_dly + DW'(1);
        w_got      = r_mem_cs & mem_ok;
        // A byte arriving on a cen edge can be used on that same edge
        w_ready    = r_have | w_got;
        w_wbyte    = r_have ? r_byte : mem_data;

        case (r_state)
            ST_IDLE: begin
                // cs and din follow on the first cen edge in START so the chip
                // bus never moves between cen edges
                if (cmd_go) begin
                    w_num   = cmd_num;
                    w_addr  = cmd_addr;
                    w_len   = cmd_len;
                    w_sent  = '0;
                    w_busy  = 1'b1;
                    w_sub   = 2'd0;
                    w_state = ST_START;
                end
            end

            ST_START: begin
                if (cen) begin
                    case (r_sub)
                        2'd0: begin
                            w_cs  = 1'b1;
                            w_din = r_num;
                            w_stn = 1'b0;
                            w_sub = 2'd1;
                        end
                        2'd1: begin
                            w_sub = 2'd2;
                        end
                        default: begin
                            w_stn = 1'b1;
                            w_sub = 2'd0;
                            if (r_len == '0) begin
                                w_finish = 1'b1;
                            end else begin
                                w_state = ST_WAITRQ;
                            end
                        end
                    endcase
                end
            end

            ST_WAITRQ: begin
                // busyn is only trusted once the chip has taken at least one byte
                if (cen) begin
                    if (busyn && (r_sent != '0)) begin
                        w_finish = 1'b1;
                    end else if (!drqn) begin
                        w_dly      = '0;
                        w_have     = 1'b0;
                        w_mem_cs   = 1'b1;
                        w_mem_addr = r_addr;
                        w_state    = ST_FETCH;
                    end
                end
            end

            ST_FETCH: begin
                // Memory capture runs at clk rate, the delay at cen rate
                if (w_got) begin
                    w_byte   = mem_data;
                    w_have   = 1'b1;
                    w_mem_cs = 1'b0;
                    w_addr   = r_addr + AW'(1);
                end
                if (cen) begin
                    w_dly = w_dly_inc;
                    if (w_ready && (w_dly_inc == DLY_MAX)) begin
                        w_din   = w_wbyte;
                        w_sub   = 2'd0;
                        w_state = ST_WRITE;
                    end
                end
            end

            ST_WRITE: begin
                // din was set one cen earlier; wrn low for two cen ticks
                if (cen) begin
                    case (r_sub)
                        2'd0: begin
                            w_wrn = 1'b0;
                            w_sub = 2'd1;
                        end
                        2'd1: begin
                            w_sub = 2'd2;
                        end
                        default: begin
                            w_wrn   = 1'b1;
                            w_sub   = 2'd0;
                            w_sent  = r_sent + LW'(1);
                            w_state = ST_RELEASE;
                        end
                    endcase
                end
            end

            ST_RELEASE: begin
                // Waiting for drqn high guarantees one write per request
                if (cen && drqn) begin
                    if (r_sent == r_len) begin
                        w_finish = 1'b1;
                    end else begin
                        w_state = ST_WAITRQ;
                    end
                end
            end

            default: begin
                w_state = ST_IDLE;
            end
        endcase

        if (w_finish) begin
            w_done   = 1'b1;
            w_busy   = 1'b0;
            w_cs     = 1'b0;
            w_stn    = 1'b1;
            w_wrn    = 1'b1;
            w_mem_cs = 1'b0;
            w_state  = ST_IDLE;
        end

        if (cmd_stop && (r_state != ST_IDLE)) begin
            w_done   = 1'b0;
            w_busy   = 1'b0;
            w_cs     = 1'b0;
            w_stn    = 1'b1;
            w_wrn    = 1'b1;
            w_mem_cs = 1'b0;
            w_sent   = r_sent;
            w_state  = ST_IDLE;
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign sent     = r_sent;
    assign stn      = r_stn;
    assign cs       = r_cs;
    assign wrn      = r_wrn;
    assign din      = r_din;
    assign mem_cs   = r_mem_cs;
    assign mem_addr = r_mem_addr;

endmodule
